// File: rtl/tmr_pkg.sv
// Shared types and constants for the TMR channel monitor.
package tmr_pkg;

    // Width of the per-channel miss and recovery counters
    localparam int CNT_W = 4;

    // Per-channel health state
    typedef enum logic [1:0] {
        ACTIVE  = 2'd0,
        SUSPECT = 2'd1,
        FAILED  = 2'd2
    } ch_state_t;

    // failed_ch encodings
    localparam logic [1:0] FCH_NONE = 2'd0;
    localparam logic [1:0] FCH_1    = 2'd1;
    localparam logic [1:0] FCH_2    = 2'd2;
    localparam logic [1:0] FCH_3    = 2'd3;

endpackage

// File: rtl/tmr_channel_fsm.sv
// Per-channel health FSM: ACTIVE / SUSPECT / FAILED with a miss counter.
// Optional recovery of a FAILED channel under TMR_RECOVERY_EN.
module tmr_channel_fsm
    import tmr_pkg::*;
#(
    parameter int MISS_LIMIT = 4
`ifdef TMR_RECOVERY_EN
   ,parameter int REC_LIMIT  = 8
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic miss_evt,    // strobed sample where this channel is the minority
    input  logic agree_evt,   // strobed sample where this channel agrees
`ifdef TMR_RECOVERY_EN
    input  logic rec_hit,     // strobed sample matching the agreeing active pair
    input  logic rec_clr,     // strobed sample that breaks the agreement run
`endif
    output logic en
);

    localparam logic [CNT_W-1:0] MISS_LIM_C = CNT_W'(MISS_LIMIT);

    ch_state_t        state, state_n;
    logic [CNT_W-1:0] miss, miss_n;
    logic [CNT_W-1:0] miss_inc;

    assign miss_inc = miss + CNT_W'(1);

`ifdef TMR_RECOVERY_EN
    localparam logic [CNT_W-1:0] REC_LIM_C = CNT_W'(REC_LIMIT);
    logic [CNT_W-1:0] rec, rec_n;
    logic [CNT_W-1:0] rec_inc;

    assign rec_inc = rec + CNT_W'(1);
`endif

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACTIVE;
            miss  <= '0;
`ifdef TMR_RECOVERY_EN
            rec   <= '0;
`endif
        end else begin
            state <= state_n;
            miss  <= miss_n;
`ifdef TMR_RECOVERY_EN
            rec   <= rec_n;
`endif
        end
    end

    // Next-state and counter update
    always_comb begin
        state_n = state;
        miss_n  = miss;
`ifdef TMR_RECOVERY_EN
        rec_n   = rec;
`endif
        case (state)
            ACTIVE: begin
                if (miss_evt) begin
                    miss_n  = CNT_W'(1);
                    state_n = (MISS_LIMIT == 1) ? FAILED : SUSPECT;
                end
            end
            SUSPECT: begin
                if (miss_evt) begin
                    miss_n = miss_inc;
                    if (miss_inc >= MISS_LIM_C) state_n = FAILED;
                end else if (agree_evt) begin
                    miss_n  = '0;
                    state_n = ACTIVE;
                end
            end
            FAILED: begin
`ifdef TMR_RECOVERY_EN
                if (rec_hit) begin
                    if (rec_inc >= REC_LIM_C) begin
                        state_n = ACTIVE;
                        miss_n  = '0;
                        rec_n   = '0;
                    end else begin
                        rec_n = rec_inc;
                    end
                end else if (rec_clr) begin
                    rec_n = '0;
                end
`endif
            end
            default: state_n = ACTIVE;
        endcase
    end

    // Channel enable: everything except FAILED feeds the voters
    always_comb begin
        en = (state != FAILED);
    end

endmodule

// File: rtl/tmr_channel_monitor.sv
// TMR channel monitor: majority/permission/status logic around three
// per-channel health FSMs. Build option: TMR_RECOVERY_EN enables
// automatic restoration of a FAILED channel after REC_LIMIT agreements.
module tmr_channel_monitor
    import tmr_pkg::*;
#(
    parameter int MISS_LIMIT = 4,
    parameter int REC_LIMIT  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       strobe,
    input  logic       a1,
    input  logic       a2,
    input  logic       a3,
    input  logic       clr,
    output logic       en1,
    output logic       en2,
    output logic       en3,
    output logic       miscompare,
    output logic       unresolved,
    output logic [1:0] failed_ch
);

    if (MISS_LIMIT < 1 || MISS_LIMIT > 15) begin : g_bad_miss_limit
        $error("MISS_LIMIT must be 1..15");
    end
    if (REC_LIMIT < 1 || REC_LIMIT > 15) begin : g_bad_rec_limit
        $error("REC_LIMIT must be 1..15");
    end

    logic [2:0] a, act, ones;
    logic [2:0] miss_evt, agree_evt;
    logic       all_act, all_eq, ref_val, maj, unr_set;

    assign a       = {a3, a2, a1};
    assign all_act = &act;
    assign maj     = (a[0] & a[1]) | (a[0] & a[2]) | (a[1] & a[2]);
    // Values of the non-FAILED channels only; they agree if all 0 or all 1
    assign ones    = a & act;
    assign all_eq  = (ones == 3'b000) || (ones == act);
    assign ref_val = |ones;
    // Two remaining channels disagree: no way to tell which one is wrong
    assign unr_set = strobe & ~all_act & ~all_eq;

    for (genvar i = 0; i < 3; i++) begin : g_ch
        // Only a full triplet can name a minority, so failing needs 3 active
        assign miss_evt[i]  = strobe & all_act & (a[i] != maj);
        assign agree_evt[i] = strobe & act[i] & (all_act ? (a[i] == maj) : all_eq);

`ifdef TMR_RECOVERY_EN
        logic rec_hit, rec_clr;
        assign rec_hit = strobe & ~act[i] & all_eq & (a[i] == ref_val);
        assign rec_clr = strobe & ~rec_hit;
`endif

        tmr_channel_fsm #(
            .MISS_LIMIT (MISS_LIMIT)
`ifdef TMR_RECOVERY_EN
           ,.REC_LIMIT  (REC_LIMIT)
`endif
        ) u_fsm (
            .clk       (clk),
            .rst_n     (rst_n),
            .miss_evt  (miss_evt[i]),
            .agree_evt (agree_evt[i]),
`ifdef TMR_RECOVERY_EN
            .rec_hit   (rec_hit),
            .rec_clr   (rec_clr),
`endif
            .en        (act[i])
        );
    end

    assign en1 = act[0];
    assign en2 = act[1];
    assign en3 = act[2];

    // Miscompare pulse and sticky unresolved flag (set beats clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miscompare <= 1'b0;
            unresolved <= 1'b0;
        end else begin
            miscompare <= strobe & ~all_eq;
            if (unr_set)  unresolved <= 1'b1;
            else if (clr) unresolved <= 1'b0;
        end
    end

    // Failed-channel index decoded from the channel enables
    always_comb begin
        failed_ch = FCH_NONE;
        if (!act[0])      failed_ch = FCH_1;
        else if (!act[1]) failed_ch = FCH_2;
        else if (!act[2]) failed_ch = FCH_3;
    end

    logic unused_ref;
`ifdef TMR_RECOVERY_EN
    assign unused_ref = 1'b0;
`else
    assign unused_ref = ref_val;
`endif

endmodule

// File: tb/tb_tmr_channel_monitor.sv
// Directed bench for tmr_channel_monitor (MISS_LIMIT=4, REC_LIMIT=8) plus a
// MISS_LIMIT=1 instance for the direct ACTIVE->FAILED path.
module tb_tmr_channel_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       strobe = 1'b0;
    logic       a1 = 1'b0, a2 = 1'b0, a3 = 1'b0;
    logic       clr = 1'b0;
    logic       en1, en2, en3, miscompare, unresolved;
    logic [1:0] failed_ch;
    logic       m_en1, m_en2, m_en3, m_mc, m_unr;
    logic [1:0] m_fch;

    int n_chk = 0;
    int n_err = 0;
    int mc_cnt = 0;

    wire [2:0] en   = {en3, en2, en1};
    wire [2:0] m_en = {m_en3, m_en2, m_en1};

    always #5 clk = ~clk;

    tmr_channel_monitor #(.MISS_LIMIT(4), .REC_LIMIT(8)) dut (
        .clk(clk), .rst_n(rst_n), .strobe(strobe), .a1(a1), .a2(a2), .a3(a3),
        .clr(clr), .en1(en1), .en2(en2), .en3(en3), .miscompare(miscompare),
        .unresolved(unresolved), .failed_ch(failed_ch)
    );

    tmr_channel_monitor #(.MISS_LIMIT(1), .REC_LIMIT(8)) dut_m1 (
        .clk(clk), .rst_n(rst_n), .strobe(strobe), .a1(a1), .a2(a2), .a3(a3),
        .clr(clr), .en1(m_en1), .en2(m_en2), .en3(m_en3), .miscompare(m_mc),
        .unresolved(m_unr), .failed_ch(m_fch)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One strobed sample; v = {a3,a2,a1}. Returns 1 time unit after the edge.
    task automatic stb(input logic [2:0] v);
        @(negedge clk);
        {a3, a2, a1} = v;
        strobe = 1'b1;
        @(posedge clk);
        #1;
        if (miscompare) mc_cnt++;
    endtask

    task automatic idle();
        @(negedge clk);
        strobe = 1'b0;
        clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Assert reset between clock edges and release on the next falling edge
    task automatic async_reset_check(input string tag);
        #2;
        rst_n = 1'b0;
        strobe = 1'b0;
        #1;
        chk({tag, "_en"}, 8'(en), 8'd7);
        chk({tag, "_fch"}, 8'(failed_ch), 8'd0);
        chk({tag, "_miss2"}, 8'(dut.g_ch[1].u_fsm.miss), 8'd0);
        chk({tag, "_st2"}, 8'(dut.g_ch[1].u_fsm.state), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        chk("rst_en", 8'(en), 8'd7);
        chk("rst_mc", 8'(miscompare), 8'd0);
        chk("rst_unr", 8'(unresolved), 8'd0);
        chk("rst_fch", 8'(failed_ch), 8'd0);
        rst_n = 1'b1;

        // All channels agree for 10 strobes
        mc_cnt = 0;
        repeat (10) stb(3'b111);
        chk("agree_mc", 8'(mc_cnt), 8'd0);
        chk("agree_en", 8'(en), 8'd7);
        chk("agree_fch", 8'(failed_ch), 8'd0);
        idle();

        // a3 inverted on 4 consecutive strobes
        mc_cnt = 0;
        stb(3'b011);
        chk("ml1_en", 8'(m_en), 8'b011);
        chk("ml1_fch", 8'(m_fch), 8'd3);
        chk("f3_mc1", 8'(miscompare), 8'd1);
        stb(3'b011);
        stb(3'b011);
        chk("f3_en_s3", 8'(en), 8'd7);
        stb(3'b011);
        chk("f3_en_s4", 8'(en), 8'b011);
        chk("f3_fch", 8'(failed_ch), 8'd3);
        chk("f3_mccnt", 8'(mc_cnt), 8'd4);
        idle();
        chk("idle_mc", 8'(miscompare), 8'd0);

        // Two active channels disagree with channel 3 failed
        stb(3'b001);
        chk("unr_set", 8'(unresolved), 8'd1);
        chk("unr_mc", 8'(miscompare), 8'd1);
        chk("unr_en", 8'(en), 8'b011);
        idle();
        chk("unr_sticky", 8'(unresolved), 8'd1);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("unr_clr", 8'(unresolved), 8'd0);
        // clear coinciding with a new unresolved event: set wins
        @(negedge clk);
        clr = 1'b1;
        {a3, a2, a1} = 3'b001;
        strobe = 1'b1;
        @(posedge clk);
        #1;
        chk("unr_setwins", 8'(unresolved), 8'd1);
        chk("unr_en2", 8'(en), 8'b011);
        idle();

        // Reset while channel 3 is FAILED
        async_reset_check("arst_fail");
        chk("arst_unr", 8'(unresolved), 8'd0);

        // a2 inverted 3, agrees 1, inverted 3
        stb(3'b101);
        stb(3'b101);
        stb(3'b101);
        chk("sus_miss3", 8'(dut.g_ch[1].u_fsm.miss), 8'd3);
        stb(3'b111);
        chk("sus_miss0", 8'(dut.g_ch[1].u_fsm.miss), 8'd0);
        chk("sus_st0", 8'(dut.g_ch[1].u_fsm.state), 8'd0);
        stb(3'b101);
        stb(3'b101);
        stb(3'b101);
        chk("sus_en", 8'(en), 8'd7);
        chk("sus_miss3b", 8'(dut.g_ch[1].u_fsm.miss), 8'd3);

        // Reset mid-SUSPECT
        async_reset_check("arst_sus");

`ifdef TMR_RECOVERY_EN
        // Fail channel 1, then recover with a restart at strobe 7
        idle();
        repeat (4) stb(3'b110);
        chk("rec_fail_en", 8'(en), 8'b110);
        chk("rec_fail_fch", 8'(failed_ch), 8'd1);
        repeat (6) stb(3'b111);
        stb(3'b110);
        repeat (7) stb(3'b111);
        chk("rec_7_en", 8'(en), 8'b110);
        chk("rec_7_fch", 8'(failed_ch), 8'd1);
        stb(3'b111);
        chk("rec_8_en", 8'(en), 8'd7);
        chk("rec_8_fch", 8'(failed_ch), 8'd0);
        idle();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
